lsu_initiator: RTL and testbench
================================

LSU_INITIATOR -- requirements
Module: lsu_initiator

Interface
REQ-001 SHALL have a single clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_op  input  2  00 LOAD, 01 STORE, 10 FILL, 11 COPY.
REQ-007 req_addr  input  8  LOAD/STORE/FILL address; COPY source base.
REQ-008 req_wdata  input  8  STORE/FILL data; COPY destination base.
REQ-009 req_len  input  8  FILL/COPY byte count; 0 = no memory access.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_data  output  8  LOAD result; unchanged by other ops.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 mem_we  output  1  data-memory write enable.
REQ-014 mem_addr  output  8  data-memory address.
REQ-015 mem_wdata  output  8  data-memory write data.
REQ-016 mem_rdata  input  8  data-memory read data; combinational from mem_addr, same cycle.

Function
REQ-017 SHALL implement the states IDLE, LOAD, STORE, FILL, COPY_RD, COPY_WR and DONE.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-019 On accept, the block SHALL latch op, addr, wdata and len, and SHALL ignore request inputs until it returns to IDLE.
REQ-020 Accept transitions SHALL be: LOAD->LOAD, STORE->STORE, FILL->FILL, COPY->COPY_RD; FILL or COPY with len=0 SHALL go directly to DONE.
REQ-021 In LOAD, the block SHALL drive mem_addr=addr and mem_we=0 for one cycle, capture mem_rdata into resp_data at the end of that cycle, then go to DONE.
REQ-022 In STORE, the block SHALL drive mem_we=1, mem_addr=addr and mem_wdata=wdata for exactly one cycle, then go to DONE.
REQ-023 In FILL, the block SHALL drive mem_we=1 and mem_wdata=wdata for len consecutive cycles at addresses addr, addr+1, ..., addr+len-1, then go to DONE.
REQ-024 For COPY, each byte SHALL take two cycles:
  - COPY_RD: mem_we=0, mem_addr=src; mem_rdata latched into an internal buffer.
  - COPY_WR: mem_we=1, mem_addr=dst, mem_wdata=buffer.
  - Repeat len times, then go to DONE.
REQ-025 All address increments SHALL be modulo 256 (255 wraps to 0), independently for src and dst.
REQ-026 A FILL or COPY SHALL take exactly len (FILL) or 2*len (COPY) memory cycles, plus one DONE cycle.
REQ-027 DONE SHALL assert resp_valid=1 for exactly one cycle, with req_ready=0, then return to IDLE.
REQ-028 In IDLE, DONE, LOAD and COPY_RD, mem_we SHALL be 0.
REQ-029 In IDLE, mem_addr and mem_wdata SHALL hold their last driven values.
REQ-030 A COPY with overlapping ranges SHALL proceed strictly ascending with no hazard handling; overwritten source bytes are read back as already written.
REQ-031 A request with req_valid=1 while the block is busy SHALL NOT be accepted and SHALL NOT alter the operation in progress.

Reset
REQ-032 While reset=0, the block SHALL hold state=IDLE and drive: mem_we=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_data=0, busy=0, req_ready=0.
REQ-033 Reset asserted mid-operation SHALL deassert mem_we immediately (combinationally from the reset state) and abandon the operation without asserting resp_valid.
REQ-034 req_ready SHALL be 1 from the first rising edge after reset deasserts.

Verification
REQ-035 STORE addr=0x10, wdata=0xA5, then LOAD addr=0x10 -> exactly one mem_we pulse at 0x10/0xA5; LOAD resp_data=0xA5; each response is a single resp_valid pulse, two cycles after accept.
REQ-036 FILL addr=0xFE, wdata=0x3C, len=4 -> writes at 0xFE, 0xFF, 0x00, 0x01 on 4 consecutive cycles; resp_valid on the 5th cycle after accept.
REQ-037 COPY src=0x20, dst=0x80, len=3, with mem[0x20..0x22]=11,22,33 -> mem[0x80..0x82]=11,22,33; 6 memory cycles; mem_we alternates 0,1.
REQ-038 FILL len=0 and COPY len=0 -> no mem_we; resp_valid one cycle after accept; resp_data unchanged.
REQ-039 reset pulsed low during cycle 3 of FILL len=10 -> mem_we=0 immediately, no resp_valid, req_ready=1 after release, next LOAD works.
REQ-040 req_valid held high continuously during a COPY with changing req_op/req_addr -> no second accept until after DONE; the COPY result is unaffected.

Source files
------------

// File: rtl/lsu_initiator.sv
// lsu_initiator: single-request load/store unit driving a combinational-read data memory.
// Handles LOAD, STORE, FILL (repeated write) and COPY (read/write pairs), one op at a time.
`default_nettype none

module lsu_initiator (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  input  logic [7:0] req_len,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic       busy,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_COPY  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_STORE   = 3'd2,
    S_FILL    = 3'd3,
    S_COPY_RD = 3'd4,
    S_COPY_WR = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t     state_q;
  logic       req_ready_q;
  logic       resp_valid_q;
  logic [7:0] resp_data_q;
  logic       busy_q;
  logic       mem_we_q;
  logic [7:0] mem_addr_q;
  logic [7:0] mem_wdata_q;
  logic [7:0] src_q;
  logic [7:0] dst_q;
  logic [7:0] cnt_q;

  // Outputs are registered alongside the state so each state's memory
  // controls are valid for the whole cycle the state is active.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 8'd0;
      busy_q       <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 8'd0;
      mem_wdata_q  <= 8'd0;
      src_q        <= 8'd0;
      dst_q        <= 8'd0;
      cnt_q        <= 8'd0;
    end else begin
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            src_q       <= req_addr;
            dst_q       <= req_wdata;
            cnt_q       <= req_len;
            case (req_op)
              OP_LOAD: begin
                state_q    <= S_LOAD;
                mem_addr_q <= req_addr;
              end
              OP_STORE: begin
                state_q     <= S_STORE;
                mem_we_q    <= 1'b1;
                mem_addr_q  <= req_addr;
                mem_wdata_q <= req_wdata;
              end
              OP_FILL: begin
                if (req_len == 8'd0) begin
                  state_q      <= S_DONE;
                  resp_valid_q <= 1'b1;
                end else begin
                  state_q     <= S_FILL;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= req_addr;
                  mem_wdata_q <= req_wdata;
                end
              end
              default: begin
                if (req_len == 8'd0) begin
                  state_q      <= S_DONE;
                  resp_valid_q <= 1'b1;
                end else begin
                  state_q    <= S_COPY_RD;
                  mem_addr_q <= req_addr;
                end
              end
            endcase
          end
        end
        S_LOAD: begin
          resp_data_q  <= mem_rdata;
          state_q      <= S_DONE;
          resp_valid_q <= 1'b1;
        end
        S_STORE: begin
          state_q      <= S_DONE;
          resp_valid_q <= 1'b1;
        end
        S_FILL: begin
          if (cnt_q == 8'd1) begin
            state_q      <= S_DONE;
            resp_valid_q <= 1'b1;
          end else begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= mem_addr_q + 8'd1;
            cnt_q      <= cnt_q - 8'd1;
          end
        end
        S_COPY_RD: begin
          // mem_wdata_q doubles as the copy buffer for the following write
          state_q     <= S_COPY_WR;
          mem_we_q    <= 1'b1;
          mem_addr_q  <= dst_q;
          mem_wdata_q <= mem_rdata;
          src_q       <= src_q + 8'd1;
        end
        S_COPY_WR: begin
          dst_q <= dst_q + 8'd1;
          if (cnt_q == 8'd1) begin
            state_q      <= S_DONE;
            resp_valid_q <= 1'b1;
          end else begin
            cnt_q      <= cnt_q - 8'd1;
            state_q    <= S_COPY_RD;
            mem_addr_q <= src_q;
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign busy       = busy_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_initiator.sv
// tb_lsu_initiator: directed self-checking bench for lsu_initiator with a 256-byte memory model.
`default_nettype none

module tb_lsu_initiator;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic [7:0] req_len;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       busy;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] mem [256];
  int n_checks = 0;
  int n_errors = 0;
  int we_count = 0;
  int rv_count = 0;

  lsu_initiator dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_len    (req_len),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .busy       (busy),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_count <= we_count + 1;
    end
    if (resp_valid) rv_count <= rv_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single edge; returns in the first cycle after accept.
  task automatic do_req(input logic [1:0] op, input logic [7:0] a, input logic [7:0] w,
                        input logic [7:0] l);
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = w;
    req_len   = l;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic store(input logic [7:0] a, input logic [7:0] w);
    do_req(2'b01, a, w, 8'd0);
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fill_addrs [4];
    logic [7:0] copy_data  [3];
    int we_before;
    int rv_before;

    fill_addrs[0] = 8'hFE; fill_addrs[1] = 8'hFF; fill_addrs[2] = 8'h00; fill_addrs[3] = 8'h01;
    copy_data[0]  = 8'h11; copy_data[1]  = 8'h22; copy_data[2]  = 8'h33;

    reset = 1'b0; req_valid = 1'b0; req_op = 2'b00;
    req_addr = 8'd0; req_wdata = 8'd0; req_len = 8'd0;
    #2;
    chk("rst_mem_we",     {31'd0, mem_we},     32'd0);
    chk("rst_mem_addr",   {24'd0, mem_addr},   32'd0);
    chk("rst_mem_wdata",  {24'd0, mem_wdata},  32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data",  {24'd0, resp_data},  32'd0);
    chk("rst_busy",       {31'd0, busy},       32'd0);
    chk("rst_req_ready",  {31'd0, req_ready},  32'd0);

    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // STORE 0x10 <- 0xA5
    we_before = we_count;
    do_req(2'b01, 8'h10, 8'hA5, 8'd0);
    chk("st_we",    {31'd0, mem_we},    32'd1);
    chk("st_addr",  {24'd0, mem_addr},  32'h10);
    chk("st_wdata", {24'd0, mem_wdata}, 32'hA5);
    chk("st_busy",  {31'd0, busy},      32'd1);
    chk("st_ready", {31'd0, req_ready}, 32'd0);
    chk("st_rv_c1", {31'd0, resp_valid}, 32'd0);
    tick();
    chk("st_we_c2", {31'd0, mem_we},    32'd0);
    chk("st_rv_c2", {31'd0, resp_valid}, 32'd1);
    chk("st_rdy_c2", {31'd0, req_ready}, 32'd0);
    tick();
    chk("st_rv_c3", {31'd0, resp_valid}, 32'd0);
    chk("st_busy_c3", {31'd0, busy},    32'd0);
    chk("st_we_count", we_count - we_before, 32'd1);

    // LOAD 0x10
    do_req(2'b00, 8'h10, 8'h00, 8'd0);
    chk("ld_we",   {31'd0, mem_we},    32'd0);
    chk("ld_addr", {24'd0, mem_addr},  32'h10);
    chk("ld_rv_c1", {31'd0, resp_valid}, 32'd0);
    tick();
    chk("ld_rv_c2", {31'd0, resp_valid}, 32'd1);
    chk("ld_data", {24'd0, resp_data}, 32'hA5);
    tick();
    chk("ld_rv_c3", {31'd0, resp_valid}, 32'd0);

    // FILL 0xFE len 4 wraps through 0x00
    do_req(2'b10, 8'hFE, 8'h3C, 8'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill_we_%0d", i),    {31'd0, mem_we},    32'd1);
      chk($sformatf("fill_addr_%0d", i),  {24'd0, mem_addr},  {24'd0, fill_addrs[i]});
      chk($sformatf("fill_wdata_%0d", i), {24'd0, mem_wdata}, 32'h3C);
      chk($sformatf("fill_rv_%0d", i),    {31'd0, resp_valid}, 32'd0);
      tick();
    end
    chk("fill_we_done", {31'd0, mem_we},     32'd0);
    chk("fill_rv_done", {31'd0, resp_valid}, 32'd1);
    tick();
    chk("fill_mem_00",  {24'd0, mem[8'h00]}, 32'h3C);
    chk("fill_mem_ff",  {24'd0, mem[8'hFF]}, 32'h3C);

    // COPY 0x20..0x22 -> 0x80..0x82 with req_valid held and inputs churning
    store(8'h20, 8'h11);
    store(8'h21, 8'h22);
    store(8'h22, 8'h33);
    rv_before = rv_count;
    do_req(2'b11, 8'h20, 8'h80, 8'd3);
    req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_op   = 2'(i);
      req_addr = 8'(8'h40 + i);
      chk($sformatf("cp_we_%0d", i),   {31'd0, mem_we}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("cp_addr_%0d", i), {24'd0, mem_addr},
          (i % 2 == 1) ? 32'(8'h80 + i / 2) : 32'(8'h20 + i / 2));
      if (i % 2 == 1)
        chk($sformatf("cp_wdata_%0d", i), {24'd0, mem_wdata}, {24'd0, copy_data[i / 2]});
      chk($sformatf("cp_ready_%0d", i), {31'd0, req_ready}, 32'd0);
      tick();
    end
    chk("cp_rv_done", {31'd0, resp_valid}, 32'd1);
    chk("cp_busy_done", {31'd0, busy}, 32'd1);
    req_valid = 1'b0;
    tick();
    chk("cp_mem_80", {24'd0, mem[8'h80]}, 32'h11);
    chk("cp_mem_81", {24'd0, mem[8'h81]}, 32'h22);
    chk("cp_mem_82", {24'd0, mem[8'h82]}, 32'h33);
    chk("cp_one_resp", rv_count - rv_before, 32'd1);
    chk("cp_not_reaccepted", {31'd0, busy}, 32'd0);

    // Zero-length FILL and COPY
    we_before = we_count;
    do_req(2'b10, 8'h40, 8'h99, 8'd0);
    chk("f0_rv",   {31'd0, resp_valid}, 32'd1);
    chk("f0_data", {24'd0, resp_data},  32'hA5);
    tick();
    do_req(2'b11, 8'h40, 8'h90, 8'd0);
    chk("c0_rv",   {31'd0, resp_valid}, 32'd1);
    chk("c0_data", {24'd0, resp_data},  32'hA5);
    tick();
    chk("len0_no_we", we_count - we_before, 32'd0);

    // Reset during cycle 3 of FILL len 10
    rv_before = rv_count;
    we_before = we_count;
    do_req(2'b10, 8'h50, 8'h77, 8'd10);
    tick();
    tick();
    chk("rf_we_c3", {31'd0, mem_we}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rf_we_rst",   {31'd0, mem_we}, 32'd0);
    chk("rf_busy_rst", {31'd0, busy},   32'd0);
    chk("rf_addr_rst", {24'd0, mem_addr}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("rf_ready", {31'd0, req_ready}, 32'd1);
    chk("rf_no_resp", rv_count - rv_before, 32'd0);
    chk("rf_writes", we_count - we_before, 32'd2);
    do_req(2'b00, 8'h51, 8'h00, 8'd0);
    tick();
    chk("rf_ld_rv",   {31'd0, resp_valid}, 32'd1);
    chk("rf_ld_data", {24'd0, resp_data},  32'h77);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
